ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_if.sv | 22 ++
 rtl/ahb_arbiter.sv | 67 ++++++
 tb/tb_ahb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: shared master count and the arbitration bus bundle between masters and the arbiter.
package param_pkg;
    localparam int NUM_MASTERS = 4;
    localparam int MW = $clog2(NUM_MASTERS);
endpackage

interface ahb_arbiter_if;
    import param_pkg::*;
    logic [NUM_MASTERS-1:0] Hbusreq_M;
    logic [NUM_MASTERS-1:0] Hlock_M;
    logic [1:0]             Htrans;
    logic [2:0]             Hburst;
    logic                   Hready;
    logic [NUM_MASTERS-1:0] Hgrant_M;
    logic [MW-1:0]          Hmaster;
    logic [MW-1:0]          Hmaster_data;
    logic                   Hmastlock;
    modport master (output Hbusreq_M, Hlock_M, Htrans, Hburst, Hready,
                    input Hgrant_M, Hmaster, Hmaster_data, Hmastlock);
    modport slave (input Hbusreq_M, Hlock_M, Htrans, Hburst, Hready,
                   output Hgrant_M, Hmaster, Hmaster_data, Hmastlock);
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with fixed-length burst protection and locked transfers.
module ahb_arbiter
    import param_pkg::*;
(
    input logic         Hclk,
    input logic         Hreset,
    ahb_arbiter_if.slave b
);
    typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;
    state_t        state;
    logic [4:0]    cnt;
    logic [4:0]    len_m1;
    logic [MW-1:0] ptr, g, win;
    logic          found, lock_g, fixed_nonseq, rearb;
    always_comb begin
        g = '0;
        win = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (b.Hgrant_M[i]) g = MW'(i);
        for (int i = 1; i <= NUM_MASTERS; i++)
            if (!found && b.Hbusreq_M[MW'((int'(ptr) + i) % NUM_MASTERS)]) begin
                win = MW'((int'(ptr) + i) % NUM_MASTERS);
                found = 1'b1;
            end
    end
    assign lock_g       = b.Hlock_M[g];
    assign fixed_nonseq = b.Htrans == 2'd2 && b.Hburst >= 3'd2;
    assign len_m1       = b.Hburst < 3'd4 ? 5'd3 : b.Hburst < 3'd6 ? 5'd7 : 5'd15;
    // Handover happens one beat early so the next owner's address phase overlaps the last data beat
    assign rearb = !lock_g && (state == LOCKED || (state == ARB && !fixed_nonseq) ||
                   (state == BURST && (b.Htrans == 2'd0 || (b.Htrans == 2'd3 && cnt == 5'd2))));
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state          <= ARB;
            cnt            <= '0;
            ptr            <= '0;
            b.Hgrant_M     <= NUM_MASTERS'(1);
            b.Hmaster      <= '0;
            b.Hmaster_data <= '0;
            b.Hmastlock    <= 1'b0;
        end else if (b.Hready) begin
            b.Hmaster      <= g;
            b.Hmaster_data <= b.Hmaster;
            b.Hmastlock    <= lock_g;
            if (rearb) begin
                b.Hgrant_M <= found ? NUM_MASTERS'(1) << win : NUM_MASTERS'(1);
                if (found) ptr <= win;
            end
            if (lock_g) begin
                state <= LOCKED;
                cnt   <= '0;
            end else if (state == ARB && fixed_nonseq) begin
                state <= BURST;
                cnt   <= len_m1;
            end else if (state == BURST && b.Htrans == 2'd0) begin
                state <= ARB;
                cnt   <= '0;
            end else if (state == BURST && b.Htrans == 2'd3) begin
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) state <= ARB;
            end else if (state == LOCKED) begin
                state <= ARB;
            end
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed AHB arbitration scenarios plus randomized traffic against a rule-level reference model.
module tb_ahb_arbiter;
    import param_pkg::*;
    localparam int N = NUM_MASTERS;
    logic Hclk = 1'b0;
    logic Hreset = 1'b1;
    ahb_arbiter_if bus();
    ahb_arbiter dut (.Hclk(Hclk), .Hreset(Hreset), .b(bus));
    always #5 Hclk = ~Hclk;

    int n_cmp = 0;
    int n_bad = 0;
    // Reference model: mode 0 free, 1 burst, 2 locked; rem = beats still owed by the burst
    int m_mode, m_rem, m_ptr, m_owner, m_hm, m_hmd, m_hml;
    int len_tbl [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_ptr = 0; m_owner = 0; m_hm = 0; m_hmd = 0; m_hml = 0;
    endtask

    task automatic model_step();
        int tr, bu;
        bit rb, hit;
        if (bus.Hready !== 1'b1) return;
        tr = int'(bus.Htrans);
        bu = int'(bus.Hburst);
        rb = 0;
        m_hmd = m_hm;
        m_hm = m_owner;
        m_hml = int'(bus.Hlock_M[m_owner]);
        if (bus.Hlock_M[m_owner]) begin
            m_mode = 2; m_rem = 0;
        end else if (m_mode == 0) begin
            if (tr == 2 && len_tbl[bu] > 1) begin m_mode = 1; m_rem = len_tbl[bu] - 1; end
            else rb = 1;
        end else if (m_mode == 1) begin
            if (tr == 0) begin m_mode = 0; m_rem = 0; rb = 1; end
            else if (tr == 3) begin
                m_rem = m_rem - 1;
                if (m_rem == 1) rb = 1;
                if (m_rem == 0) m_mode = 0;
            end
        end else begin
            m_mode = 0; rb = 1;
        end
        if (rb) begin
            hit = 0;
            m_owner = 0;
            for (int k = 1; k <= N; k++)
                if (!hit && bus.Hbusreq_M[(m_ptr + k) % N]) begin
                    hit = 1; m_owner = (m_ptr + k) % N;
                end
            if (hit) m_ptr = m_owner;
        end
    endtask

    task automatic check_all();
        check("grant", 32'(bus.Hgrant_M), 32'(1) << m_owner);
        check("hmaster", 32'(bus.Hmaster), 32'(m_hm));
        check("hmaster_data", 32'(bus.Hmaster_data), 32'(m_hmd));
        check("hmastlock", 32'(bus.Hmastlock), 32'(m_hml));
        check("cnt", 32'(dut.cnt), 32'(m_rem));
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        bus.Hbusreq_M = req; bus.Hlock_M = lock; bus.Htrans = tr; bus.Hburst = bu; bus.Hready = rdy;
    endtask

    task automatic tick();
        @(posedge Hclk);
        model_step();
        @(negedge Hclk);
        check_all();
    endtask

    // Called just after a falling edge: reset must take effect without any rising edge
    task automatic reset_async();
        #2 Hreset = 1'b1;
        #1;
        model_reset();
        check("rst_grant", 32'(bus.Hgrant_M), 32'h1);
        check("rst_hmaster", 32'(bus.Hmaster), 32'h0);
        check("rst_hmaster_data", 32'(bus.Hmaster_data), 32'h0);
        check("rst_hmastlock", 32'(bus.Hmastlock), 32'h0);
        check("rst_cnt", 32'(dut.cnt), 32'h0);
        @(negedge Hclk);
        Hreset = 1'b0;
    endtask

    initial begin
        drive('0, '0, 2'd0, 3'd0, 1'b1);
        model_reset();
        @(negedge Hclk);
        check_all();
        Hreset = 1'b0;

        // Rotation between masters 1 and 2
        drive(4'b0110, '0, 2'd2, 3'd0, 1'b1);
        tick(); check("rot_g0", 32'(bus.Hgrant_M), 32'b0010);
        tick(); check("rot_g1", 32'(bus.Hgrant_M), 32'b0100);
        tick(); check("rot_g2", 32'(bus.Hgrant_M), 32'b0010);
        tick(); check("rot_g3", 32'(bus.Hgrant_M), 32'b0100);

        // Burst handover: master 1 INCR4 while master 3 waits
        reset_async();
        drive(4'b0010, '0, 2'd0, 3'd0, 1'b1); tick();
        drive(4'b1010, '0, 2'd2, 3'd3, 1'b1); tick();
        check("hand_b1", 32'(bus.Hgrant_M), 32'b0010);
        drive(4'b1010, '0, 2'd3, 3'd3, 1'b1); tick();
        check("hand_b2", 32'(bus.Hgrant_M), 32'b0010);
        tick(); check("hand_b3", 32'(bus.Hgrant_M), 32'b1000);
        tick(); check("hand_b4_hmaster", 32'(bus.Hmaster), 32'd3);

        // Stall mid-WRAP8
        reset_async();
        drive(4'b0010, '0, 2'd0, 3'd0, 1'b1); tick();
        drive(4'b1011, '0, 2'd2, 3'd4, 1'b1); tick();
        drive(4'b1011, '0, 2'd3, 3'd4, 1'b1); tick(); tick();
        drive(4'b1011, '0, 2'd3, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_cnt", 32'(dut.cnt), 32'd5);
        end
        drive(4'b1011, '0, 2'd3, 3'd4, 1'b1);
        for (int i = 0; i < 5; i++) tick();

        // Lock by master 2 against all other requesters
        reset_async();
        drive(4'b0100, '0, 2'd0, 3'd0, 1'b1); tick();
        drive(4'b1111, 4'b0100, 2'd2, 3'd0, 1'b1); tick();
        check("lock_hmaster", 32'(bus.Hmaster), 32'd2);
        check("lock_hmastlock", 32'(bus.Hmastlock), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold", 32'(bus.Hgrant_M), 32'b0100);
        end
        drive(4'b1111, '0, 2'd2, 3'd0, 1'b1); tick();
        check("unlock_grant", 32'(bus.Hgrant_M), 32'b1000);
        check("unlock_hmastlock", 32'(bus.Hmastlock), 32'd0);

        // Early termination of INCR8 after 3 beats
        reset_async();
        drive(4'b0011, '0, 2'd2, 3'd5, 1'b1); tick();
        drive(4'b0011, '0, 2'd3, 3'd5, 1'b1); tick(); tick();
        drive(4'b0011, '0, 2'd0, 3'd5, 1'b1); tick();
        check("early_grant", 32'(bus.Hgrant_M), 32'b0010);
        check("early_cnt", 32'(dut.cnt), 32'd0);

        // Reset mid-INCR8 of master 2
        reset_async();
        drive(4'b0100, '0, 2'd0, 3'd0, 1'b1); tick();
        drive(4'b0100, '0, 2'd2, 3'd5, 1'b1); tick();
        drive(4'b0100, '0, 2'd3, 3'd5, 1'b1); tick(); tick();
        reset_async();
        drive(4'b1000, '0, 2'd2, 3'd0, 1'b1); tick();
        check("post_rst_grant", 32'(bus.Hgrant_M), 32'b1000);
        check("post_rst_cnt", 32'(dut.cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] tr;
            tr = 2'($urandom_range(0, 3));
            if (m_mode == 1 && $urandom_range(0, 9) < 7) tr = 2'd3;
            drive(N'($urandom), ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, tr,
                  3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) reset_async();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
